agu_issue_queue: RTL and testbench

//  Parametrised, age-ordered, compacting reservation station for the address-generation unit.

---
 rtl/agu_iq_pkg.sv | 33 +++
 rtl/agu_oldest_select.sv | 18 +
 rtl/agu_issue_queue.sv | 173 +++++++++++++++++
 tb/tb_agu_issue_queue.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/agu_iq_pkg.sv
// agu_iq_pkg: shared defaults, entry layout and tag compare for the AGU issue queue
package agu_iq_pkg;

    localparam int IQ_DEPTH  = 8;
    localparam int IQ_DISP_W = 2;
    localparam int IQ_WB_CH  = 3;
    localparam int IQ_TAG_W  = 6;
    localparam int IQ_DATA_W = 32;
    localparam int IQ_STQ_W  = 5;
    localparam int IQ_PAY_W  = 42;
    localparam int TAG_MAX_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [IQ_TAG_W-1:0]  rs1_tag;
        logic                 rs1_rdy;
        logic [IQ_DATA_W-1:0] rs1_val;
        logic [IQ_TAG_W-1:0]  rs2_tag;
        logic                 rs2_rdy;
        logic [IQ_DATA_W-1:0] rs2_val;
        logic                 is_store;
        logic                 dep_vld;
        logic [IQ_STQ_W-1:0]  dep_num;
        logic [IQ_TAG_W-1:0]  rob;
        logic [IQ_PAY_W-1:0]  payload;
    } iq_entry_t;

    function automatic logic tag_match(input logic vld, input logic [TAG_MAX_W-1:0] a,
                                       input logic [TAG_MAX_W-1:0] b);
        return vld && (a == b);
    endfunction

endpackage

// File: rtl/agu_oldest_select.sv
// agu_oldest_select: find-first-set over a request vector; lowest index is the oldest
module agu_oldest_select #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) idx = req[i] ? IDX_W'(i) : idx;
    end

    assign found = |req;

endmodule

// File: rtl/agu_issue_queue.sv
// agu_issue_queue: age-ordered, compacting reservation station feeding the AGU
module agu_issue_queue
    import agu_iq_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int DISP_W = IQ_DISP_W,
    parameter int WB_CH  = IQ_WB_CH,
    parameter int TAG_W  = IQ_TAG_W,
    parameter int DATA_W = IQ_DATA_W,
    parameter int STQ_W  = IQ_STQ_W,
    parameter int PAY_W  = IQ_PAY_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [DISP_W-1:0]          disp_valid,
    output logic                       disp_ready,
    input  logic [DISP_W*TAG_W-1:0]    disp_rs1_tag,
    input  logic [DISP_W-1:0]          disp_rs1_rdy,
    input  logic [DISP_W*DATA_W-1:0]   disp_rs1_val,
    input  logic [DISP_W*TAG_W-1:0]    disp_rs2_tag,
    input  logic [DISP_W-1:0]          disp_rs2_rdy,
    input  logic [DISP_W*DATA_W-1:0]   disp_rs2_val,
    input  logic [DISP_W-1:0]          disp_is_store,
    input  logic [DISP_W-1:0]          disp_dep_vld,
    input  logic [DISP_W*STQ_W-1:0]    disp_dep_num,
    input  logic [DISP_W*TAG_W-1:0]    disp_rob,
    input  logic [DISP_W*PAY_W-1:0]    disp_payload,
    input  logic [WB_CH-1:0]           wb_valid,
    input  logic [WB_CH*TAG_W-1:0]     wb_tag,
    input  logic [WB_CH*DATA_W-1:0]    wb_data,
    input  logic                       st_done_valid,
    input  logic [STQ_W-1:0]           st_done_num,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [TAG_W-1:0]           iss_rob,
    output logic [DATA_W-1:0]          iss_rs1_val,
    output logic [DATA_W-1:0]          iss_rs2_val,
    output logic [PAY_W-1:0]           iss_payload,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Same layout as iq_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  rs1_tag;
        logic              rs1_rdy;
        logic [DATA_W-1:0] rs1_val;
        logic [TAG_W-1:0]  rs2_tag;
        logic              rs2_rdy;
        logic [DATA_W-1:0] rs2_val;
        logic              is_store;
        logic              dep_vld;
        logic [STQ_W-1:0]  dep_num;
        logic [TAG_W-1:0]  rob;
        logic [PAY_W-1:0]  payload;
    } entry_t;

    entry_t           q     [DEPTH];
    entry_t           q_nxt [DEPTH];
    entry_t           q_ext [DEPTH+1];
    entry_t           lane;
    logic [DEPTH-1:0] st_vec;
    logic [DEPTH-1:0] rdy_vec;
    logic [IDX_W-1:0] st_idx;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] wr;
    logic             st_found;
    logic             sel_found;
    logic             fire;
    logic             run;
    logic [DISP_W-1:0] acc;
    logic [OCC_W-1:0] n_acc;
    logic [OCC_W-1:0] occ_nxt;

    // Lowest wb channel wins: scan from the top so lower channels overwrite.
    function automatic entry_t wake(input entry_t e);
        entry_t r;
        r = e;
        for (int c = WB_CH - 1; c >= 0; c--) begin
            if (!e.rs1_rdy && tag_match(wb_valid[c], TAG_MAX_W'(e.rs1_tag),
                                        TAG_MAX_W'(wb_tag[c*TAG_W +: TAG_W]))) begin
                r.rs1_rdy = 1'b1;
                r.rs1_val = wb_data[c*DATA_W +: DATA_W];
            end
            if (!e.rs2_rdy && tag_match(wb_valid[c], TAG_MAX_W'(e.rs2_tag),
                                        TAG_MAX_W'(wb_tag[c*TAG_W +: TAG_W]))) begin
                r.rs2_rdy = 1'b1;
                r.rs2_val = wb_data[c*DATA_W +: DATA_W];
            end
        end
        if (st_done_valid && e.dep_num == st_done_num) r.dep_vld = 1'b0;
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) st_vec[i] = q[i].valid & q[i].is_store;
    end

    agu_oldest_select #(.N(DEPTH), .IDX_W(IDX_W)) u_store_sel (
        .req   (st_vec),
        .idx   (st_idx),
        .found (st_found)
    );

    // Only the oldest valid store may issue, keeping stores in program order.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            rdy_vec[i] = q[i].valid & q[i].rs1_rdy & q[i].rs2_rdy &
                         (q[i].is_store ? (st_found && st_idx == IDX_W'(i)) : ~q[i].dep_vld);
    end

    agu_oldest_select #(.N(DEPTH), .IDX_W(IDX_W)) u_issue_sel (
        .req   (rdy_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign iss_valid   = sel_found & ~flush;
    assign iss_rob     = q[sel_idx].rob;
    assign iss_rs1_val = q[sel_idx].rs1_val;
    assign iss_rs2_val = q[sel_idx].rs2_val;
    assign iss_payload = q[sel_idx].payload;
    assign disp_ready  = int'(occupancy) + DISP_W <= DEPTH;

    always_comb begin
        fire  = iss_valid & iss_ready;
        run   = disp_ready;
        n_acc = '0;
        for (int k = 0; k < DISP_W; k++) begin
            run    = run & disp_valid[k];
            acc[k] = run;
            n_acc  = n_acc + OCC_W'(run);
        end
        occ_nxt = occupancy - OCC_W'(fire) + n_acc;
        for (int i = 0; i < DEPTH; i++) q_ext[i] = q[i];
        q_ext[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++)
            q_nxt[i] = wake((fire && i >= int'(sel_idx)) ? q_ext[i+1] : q_ext[i]);
        lane = '0;
        wr   = '0;
        for (int k = 0; k < DISP_W; k++) begin
            lane.valid    = 1'b1;
            lane.rs1_tag  = disp_rs1_tag[k*TAG_W +: TAG_W];
            lane.rs1_rdy  = disp_rs1_rdy[k];
            lane.rs1_val  = disp_rs1_val[k*DATA_W +: DATA_W];
            lane.rs2_tag  = disp_rs2_tag[k*TAG_W +: TAG_W];
            lane.rs2_rdy  = disp_rs2_rdy[k];
            lane.rs2_val  = disp_rs2_val[k*DATA_W +: DATA_W];
            lane.is_store = disp_is_store[k];
            lane.dep_vld  = disp_dep_vld[k];
            lane.dep_num  = disp_dep_num[k*STQ_W +: STQ_W];
            lane.rob      = disp_rob[k*TAG_W +: TAG_W];
            lane.payload  = disp_payload[k*PAY_W +: PAY_W];
            wr = IDX_W'(occupancy - OCC_W'(fire) + OCC_W'(k));
            if (acc[k]) q_nxt[wr] = wake(lane);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
        end else begin
            occupancy <= occ_nxt;
            q         <= q_nxt;
        end
    end

endmodule

// File: tb/tb_agu_issue_queue.sv
// tb_agu_issue_queue: directed scoreboard bench for the AGU issue queue
module tb_agu_issue_queue;

    localparam int DEPTH = 8, DISP_W = 2, WB_CH = 3, TAG_W = 6, DATA_W = 32, STQ_W = 5, PAY_W = 42;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      flush;
    logic [DISP_W-1:0]         disp_valid;
    logic                      disp_ready;
    logic [DISP_W*TAG_W-1:0]   disp_rs1_tag, disp_rs2_tag, disp_rob;
    logic [DISP_W-1:0]         disp_rs1_rdy, disp_rs2_rdy, disp_is_store, disp_dep_vld;
    logic [DISP_W*DATA_W-1:0]  disp_rs1_val, disp_rs2_val;
    logic [DISP_W*STQ_W-1:0]   disp_dep_num;
    logic [DISP_W*PAY_W-1:0]   disp_payload;
    logic [WB_CH-1:0]          wb_valid;
    logic [WB_CH*TAG_W-1:0]    wb_tag;
    logic [WB_CH*DATA_W-1:0]   wb_data;
    logic                      st_done_valid;
    logic [STQ_W-1:0]          st_done_num;
    logic                      iss_valid, iss_ready;
    logic [TAG_W-1:0]          iss_rob;
    logic [DATA_W-1:0]         iss_rs1_val, iss_rs2_val;
    logic [PAY_W-1:0]          iss_payload;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    typedef struct {
        logic [TAG_W-1:0]  rob;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [PAY_W-1:0]  pay;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    agu_issue_queue #(.DEPTH(DEPTH), .DISP_W(DISP_W), .WB_CH(WB_CH), .TAG_W(TAG_W),
                      .DATA_W(DATA_W), .STQ_W(STQ_W), .PAY_W(PAY_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val),
        .disp_rs2_tag(disp_rs2_tag), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val),
        .disp_is_store(disp_is_store), .disp_dep_vld(disp_dep_vld), .disp_dep_num(disp_dep_num),
        .disp_rob(disp_rob), .disp_payload(disp_payload),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .st_done_valid(st_done_valid), .st_done_num(st_done_num),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rob(iss_rob),
        .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val), .iss_payload(iss_payload),
        .occupancy(occupancy)
    );

    function automatic logic [PAY_W-1:0] pay(input logic [TAG_W-1:0] rob);
        return {36'h9A5C3C0F1, rob};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; disp_valid = '0; disp_rs1_tag = '0; disp_rs1_rdy = '0; disp_rs1_val = '0;
        disp_rs2_tag = '0; disp_rs2_rdy = '0; disp_rs2_val = '0; disp_is_store = '0;
        disp_dep_vld = '0; disp_dep_num = '0; disp_rob = '0; disp_payload = '0;
        wb_valid = '0; wb_tag = '0; wb_data = '0; st_done_valid = 0; st_done_num = '0;
    endtask

    task automatic set_lane(input int k, input logic [TAG_W-1:0] rob,
                            input logic [TAG_W-1:0] t1, input logic r1, input logic [DATA_W-1:0] v1,
                            input logic [TAG_W-1:0] t2, input logic r2, input logic [DATA_W-1:0] v2,
                            input logic st, input logic dv, input logic [STQ_W-1:0] dn);
        disp_valid[k] = 1'b1;
        disp_rob[k*TAG_W +: TAG_W] = rob;
        disp_rs1_tag[k*TAG_W +: TAG_W] = t1; disp_rs1_rdy[k] = r1; disp_rs1_val[k*DATA_W +: DATA_W] = v1;
        disp_rs2_tag[k*TAG_W +: TAG_W] = t2; disp_rs2_rdy[k] = r2; disp_rs2_val[k*DATA_W +: DATA_W] = v2;
        disp_is_store[k] = st; disp_dep_vld[k] = dv; disp_dep_num[k*STQ_W +: STQ_W] = dn;
        disp_payload[k*PAY_W +: PAY_W] = pay(rob);
    endtask

    task automatic ready_op(input int k, input logic [TAG_W-1:0] rob, input logic st);
        set_lane(k, rob, 6'h3E, 1'b1, 32'h1000 + 32'(rob), 6'h3D, 1'b1, 32'h2000 + 32'(rob), st, 1'b0, '0);
    endtask

    task automatic exp_issue(input logic [TAG_W-1:0] rob, input logic [DATA_W-1:0] rs1,
                             input logic [DATA_W-1:0] rs2);
        exp_t e;
        e.rob = rob; e.rs1 = rs1; e.rs2 = rs2; e.pay = pay(rob);
        exp_q.push_back(e);
    endtask

    task automatic exp_ready(input logic [TAG_W-1:0] rob);
        exp_issue(rob, 32'h1000 + 32'(rob), 32'h2000 + 32'(rob));
    endtask

    task automatic set_wb(input int c, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        wb_valid[c] = 1'b1; wb_tag[c*TAG_W +: TAG_W] = t; wb_data[c*DATA_W +: DATA_W] = d;
    endtask

    // Monitor: every completed handshake is compared against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && iss_valid && iss_ready) begin
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_issue: got rob %0h, expected no issue", iss_rob);
            end else begin
                mon_e = exp_q.pop_front();
                check("iss_rob", iss_rob, mon_e.rob);
                check("iss_rs1_val", iss_rs1_val, mon_e.rs1);
                check("iss_rs2_val", iss_rs2_val, mon_e.rs2);
                check("iss_payload", iss_payload, mon_e.pay);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; iss_ready = 0; clear_inputs();
        tick(); tick();
        check("reset_occ", occupancy, 0);
        check("reset_iss_valid", iss_valid, 0);
        check("reset_disp_ready", disp_ready, 1);
        reset_n = 1;
        // two ready ops issue in age order
        ready_op(0, 6'd5, 0); ready_op(1, 6'd6, 0);
        tick(); clear_inputs();
        check("t1_occ2", occupancy, 2);
        check("t1_valid", iss_valid, 1);
        check("t1_first_rob", iss_rob, 5);
        exp_ready(6'd5); exp_ready(6'd6); iss_ready = 1;
        tick(); check("t1_occ1", occupancy, 1);
        tick(); check("t1_occ0", occupancy, 0);
        iss_ready = 0;
        // fill with rs1 waiting on tag 0x11, then broadcast on two channels
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 2; k++)
                set_lane(k, 6'(10 + 2*c + k), 6'h11, 1'b0, '0, 6'h01, 1'b1, 32'h2000 + 32'(10 + 2*c + k), 1'b0, 1'b0, '0);
            tick();
        end
        clear_inputs();
        check("full_occ", occupancy, 8);
        check("full_disp_ready", disp_ready, 0);
        check("full_iss_valid", iss_valid, 0);
        ready_op(0, 6'd18, 0); ready_op(1, 6'd19, 0);
        set_wb(1, 6'h11, 32'hDEAD); set_wb(2, 6'h11, 32'hBEEF);
        tick(); clear_inputs();
        check("full_no_overflow", occupancy, 8);
        check("wake_valid", iss_valid, 1);
        check("wake_rob", iss_rob, 10);
        check("wake_low_channel", iss_rs1_val, 32'hDEAD);
        for (int r = 10; r < 18; r++) exp_issue(6'(r), 32'hDEAD, 32'h2000 + 32'(r));
        iss_ready = 1;
        repeat (8) tick();
        iss_ready = 0;
        check("drain_occ", occupancy, 0);
        // dispatch bypass
        set_lane(0, 6'd20, 6'h07, 1'b0, '0, 6'h08, 1'b1, 32'h2014, 1'b0, 1'b0, '0);
        set_wb(0, 6'h07, 32'h1234);
        tick(); clear_inputs();
        check("bypass_valid", iss_valid, 1);
        check("bypass_rs1", iss_rs1_val, 32'h1234);
        exp_issue(6'd20, 32'h1234, 32'h2014);
        iss_ready = 1; tick(); iss_ready = 0;
        check("bypass_occ", occupancy, 0);
        // load waiting on store 3 is overtaken by a younger ready op
        ready_op(0, 6'd30, 0); disp_dep_vld[0] = 1; disp_dep_num[0 +: STQ_W] = 5'd3;
        ready_op(1, 6'd31, 0);
        tick(); clear_inputs();
        check("load_bypassed_rob", iss_rob, 31);
        exp_ready(6'd31); iss_ready = 1; tick(); iss_ready = 0;
        check("load_blocked", iss_valid, 0);
        check("load_occ", occupancy, 1);
        st_done_valid = 1; st_done_num = 5'd2;
        tick(); clear_inputs();
        check("load_wrong_store", iss_valid, 0);
        st_done_valid = 1; st_done_num = 5'd3;
        tick(); clear_inputs();
        check("load_woken_valid", iss_valid, 1);
        check("load_woken_rob", iss_rob, 30);
        exp_ready(6'd30); iss_ready = 1; tick(); iss_ready = 0;
        // stores issue in order
        ready_op(0, 6'd40, 1); ready_op(1, 6'd41, 1);
        tick(); clear_inputs();
        check("store_older_first", iss_rob, 40);
        exp_ready(6'd40); exp_ready(6'd41);
        iss_ready = 1; tick(); tick(); iss_ready = 0;
        set_lane(0, 6'd42, 6'h22, 1'b0, '0, 6'h01, 1'b1, 32'h2000 + 32'd42, 1'b1, 1'b0, '0);
        ready_op(1, 6'd43, 1);
        tick(); clear_inputs();
        check("store_younger_blocked", iss_valid, 0);
        set_wb(2, 6'h22, 32'h55);
        tick(); clear_inputs();
        check("store_older_woken", iss_rob, 42);
        exp_issue(6'd42, 32'h55, 32'h2000 + 32'd42); exp_ready(6'd43);
        iss_ready = 1; tick(); tick(); iss_ready = 0;
        check("store_occ", occupancy, 0);
        // simultaneous issue and dispatch at occupancy 6, then backpressure
        for (int c = 0; c < 3; c++) begin
            ready_op(0, 6'(50 + 2*c), 0); ready_op(1, 6'(51 + 2*c), 0);
            tick();
        end
        clear_inputs();
        check("occ6", occupancy, 6);
        check("occ6_disp_ready", disp_ready, 1);
        ready_op(0, 6'd56, 0); ready_op(1, 6'd57, 0);
        exp_ready(6'd50); iss_ready = 1;
        tick(); clear_inputs(); iss_ready = 0;
        check("occ7", occupancy, 7);
        check("occ7_disp_ready", disp_ready, 0);
        check("occ7_head", iss_rob, 51);
        repeat (3) begin
            tick();
            check("hold_rob", iss_rob, 51);
            check("hold_rs1", iss_rs1_val, 32'h1000 + 32'd51);
            check("hold_payload", iss_payload, pay(6'd51));
        end
        for (int r = 51; r < 58; r++) exp_ready(6'(r));
        iss_ready = 1;
        repeat (7) tick();
        iss_ready = 0;
        check("order_occ", occupancy, 0);
        // flush with a concurrent dispatch and a ready head
        ready_op(0, 6'd60, 0); ready_op(1, 6'd61, 0); tick();
        ready_op(0, 6'd62, 0); ready_op(1, 6'd63, 0); tick();
        clear_inputs(); ready_op(0, 6'd64, 0); tick();
        clear_inputs();
        check("pre_flush_occ", occupancy, 5);
        flush = 1; iss_ready = 1; ready_op(0, 6'd65, 0); ready_op(1, 6'd66, 0);
        #1;
        check("flush_no_issue", iss_valid, 0);
        tick(); clear_inputs(); iss_ready = 0;
        check("flush_occ", occupancy, 0);
        check("flush_iss_valid", iss_valid, 0);
        check("flush_disp_ready", disp_ready, 1);
        // lanes after a gap are ignored
        ready_op(1, 6'd67, 0); disp_valid[0] = 0;
        tick(); clear_inputs();
        check("gap_lane_ignored", occupancy, 0);
        // reset mid-operation discards entries
        ready_op(0, 6'd70, 0); ready_op(1, 6'd71, 0);
        tick(); clear_inputs();
        check("pre_reset_occ", occupancy, 2);
        reset_n = 0; tick(); reset_n = 1;
        check("midreset_occ", occupancy, 0);
        check("midreset_iss_valid", iss_valid, 0);
        for (int i = 0; i < 16 && exp_q.size() != 0; i++) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
